// File: rtl/voicegame_irq_aggregator.sv
`default_nettype none
// ============================================================================
// voicegame_irq_aggregator : Avalon-MM interrupt aggregator for the Nios II
// (optional overflow register built when IRQ_AGG_OVF_EN is defined)
// Revision: 1.0
// ============================================================================
module voicegame_irq_aggregator #(
   parameter int NUM_SRC = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               chipselect,
   input  logic [2:0]         address,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq_out
);

   logic [NUM_SRC-1:0] sync_meta_q, sync_q, sync_dly_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] mode_q, mode_d;
   logic [15:0]        readdata_q, readdata_d;
   logic               irq_out_q;

   logic               w_wr;
   logic               w_wr_pend, w_wr_mask, w_wr_mode;
   logic [NUM_SRC-1:0] w_wdata, w_w1c_pend, w_rise, w_hit;
   logic [15:0]        w_active, w_ovf_rd;
   logic               unused_wdata;

   function automatic logic [15:0] zext(input logic [NUM_SRC-1:0] v);
      zext = '0;
      zext[NUM_SRC-1:0] = v;
   endfunction

   assign w_wr         = chipselect & ~write_n;
   assign w_wr_pend    = w_wr && (address == 3'd0);
   assign w_wr_mask    = w_wr && (address == 3'd1);
   assign w_wr_mode    = w_wr && (address == 3'd2);
   assign w_wdata      = writedata[NUM_SRC-1:0];
   assign unused_wdata = ^writedata;
   assign w_w1c_pend   = w_wr_pend ? w_wdata : '0;
   assign w_rise       = sync_q & ~sync_dly_q;
   assign w_hit        = pending_q & mask_q;

   // Lowest index wins, so scan downward and let later hits overwrite.
   always_comb begin
      w_active = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_active[15]  = 1'b1;
            w_active[3:0] = 4'(i);
         end
      end
   end

   // A fresh rise beats a same-cycle W1C; a mode flip discards stale state.
   always_comb begin
      pending_d = (mode_q & (w_rise | (pending_q & ~w_w1c_pend))) | (~mode_q & sync_q);
      if (w_wr_mode) begin
         pending_d = pending_d & ~(mode_q ^ w_wdata);
      end
   end

   assign mask_d = w_wr_mask ? w_wdata : mask_q;
   assign mode_d = w_wr_mode ? w_wdata : mode_q;

`ifdef IRQ_AGG_OVF_EN
   logic [NUM_SRC-1:0] ovf_q, ovf_d, w_w1c_ovf;

   assign w_w1c_ovf = (w_wr && (address == 3'd5)) ? w_wdata : '0;
   assign ovf_d     = (ovf_q & ~w_w1c_ovf) | (mode_q & w_rise & pending_q & ~w_w1c_pend);
   assign w_ovf_rd  = zext(ovf_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`else
   assign w_ovf_rd = '0;
`endif

   always_comb begin
      readdata_d = '0;
      case (address)
         3'd0:    readdata_d = zext(pending_q);
         3'd1:    readdata_d = zext(mask_q);
         3'd2:    readdata_d = zext(mode_q);
         3'd3:    readdata_d = w_active;
         3'd4:    readdata_d = zext(sync_q);
         3'd5:    readdata_d = w_ovf_rd;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta_q <= '0;
         sync_q      <= '0;
         sync_dly_q  <= '0;
         pending_q   <= '0;
         mask_q      <= '0;
         mode_q      <= '0;
         readdata_q  <= '0;
         irq_out_q   <= 1'b0;
      end else begin
         sync_meta_q <= irq_in;
         sync_q      <= sync_meta_q;
         sync_dly_q  <= sync_q;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         mode_q      <= mode_d;
         readdata_q  <= readdata_d;
         irq_out_q   <= |w_hit;
      end
   end

   assign readdata = readdata_q;
   assign irq_out  = irq_out_q;

endmodule
`default_nettype wire

// File: tb/tb_voicegame_irq_aggregator.sv
`default_nettype none
// ============================================================================
// tb_voicegame_irq_aggregator : directed + randomized check against a
// cycle-history reference model. Revision: 1.0
// ============================================================================
module tb_voicegame_irq_aggregator;

   localparam int          N     = 4;
   localparam logic [15:0] NMASK = 16'h000F;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic          chipselect = 1'b0;
   logic [2:0]    address    = 3'd0;
   logic          write_n    = 1'b1;
   logic [15:0]   writedata  = 16'h0;
   logic [15:0]   readdata;
   logic [N-1:0]  irq_in     = '0;
   logic          irq_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   voicegame_irq_aggregator #(.NUM_SRC(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq_out    (irq_out)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0]  m_pend, m_mask, m_mode, m_ovf, exp_rd;
   logic [15:0]  nxt_pend, nxt_ovf, w1c, w1c_ovf, wd;
   logic         exp_irq, is_wr;
   logic [N-1:0] lvl, rise;
   logic [N-1:0] past [$];   // past[k] = irq_in sampled k+1 edges ago

   function automatic logic [15:0] m_active(input logic [15:0] hits);
      for (int i = 0; i < N; i++) begin
         if (hits[i]) return 16'h8000 | 16'(i);
      end
      return 16'h0000;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pend = '0; m_mask = '0; m_mode = '0; m_ovf = '0;
         exp_rd = '0; exp_irq = 1'b0;
         past = '{4'h0, 4'h0, 4'h0};
      end else begin
         lvl   = past[1];
         rise  = past[1] & ~past[2];
         is_wr = chipselect && !write_n;
         wd    = writedata & NMASK;
         case (address)
            3'd0: exp_rd = m_pend;
            3'd1: exp_rd = m_mask;
            3'd2: exp_rd = m_mode;
            3'd3: exp_rd = m_active(m_pend & m_mask);
            3'd4: exp_rd = {12'h0, lvl};
            3'd5: begin
`ifdef IRQ_AGG_OVF_EN
               exp_rd = m_ovf;
`else
               exp_rd = 16'h0;
`endif
            end
            default: exp_rd = 16'h0;
         endcase
         exp_irq = |(m_pend & m_mask);
         w1c     = (is_wr && address == 3'd0) ? wd : 16'h0;
         w1c_ovf = (is_wr && address == 3'd5) ? wd : 16'h0;
         nxt_pend = '0;
         nxt_ovf  = m_ovf;
         for (int i = 0; i < N; i++) begin
            if (m_mode[i]) nxt_pend[i] = rise[i] | (m_pend[i] & ~w1c[i]);
            else           nxt_pend[i] = lvl[i];
            if (w1c_ovf[i]) nxt_ovf[i] = 1'b0;
            if (m_mode[i] && rise[i] && m_pend[i] && !w1c[i]) nxt_ovf[i] = 1'b1;
         end
         if (is_wr && address == 3'd2) begin
            nxt_pend = nxt_pend & ~(wd ^ m_mode);
            m_mode   = wd;
         end
         if (is_wr && address == 3'd1) m_mask = wd;
         m_pend = nxt_pend;
         m_ovf  = nxt_ovf;
         past.push_front(irq_in);
         void'(past.pop_back());
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         check("model_readdata", readdata, exp_rd);
         check("model_irq_out", {15'h0, irq_out}, {15'h0, exp_irq});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick(1);
      chipselect = 1'b0;
      check(name, readdata, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] ovf_exp;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      tick(1);

      for (int a = 0; a < 8; a++) rd_chk("reset_read", 3'(a), 16'h0000);
      check("reset_irq_out", {15'h0, irq_out}, 16'h0);

      // Level mode latency on the timer source
      wr(3'd1, 16'h0001);
      irq_in[0] = 1'b1;
      tick(3); check("lvl_rise_edge3", {15'h0, irq_out}, 16'h0);
      tick(1); check("lvl_rise_edge4", {15'h0, irq_out}, 16'h1);
      rd_chk("lvl_active", 3'd3, 16'h8000);
      irq_in[0] = 1'b0;
      tick(3); check("lvl_fall_edge3", {15'h0, irq_out}, 16'h1);
      tick(1); check("lvl_fall_edge4", {15'h0, irq_out}, 16'h0);

      // Edge mode single-clock pulse, then W1C
      wr(3'd2, 16'h0002);
      wr(3'd1, 16'h0002);
      irq_in[1] = 1'b1; tick(1); irq_in[1] = 1'b0;
      tick(5);
      rd_chk("edge_pending", 3'd0, 16'h0002);
      rd_chk("edge_active", 3'd3, 16'h8001);
      check("edge_irq_set", {15'h0, irq_out}, 16'h1);
      wr(3'd0, 16'h0002);
      check("w1c_irq_edge1", {15'h0, irq_out}, 16'h1);
      tick(1);
      check("w1c_irq_edge2", {15'h0, irq_out}, 16'h0);

      // Priority between edge sources 0 and 2
      wr(3'd2, 16'h0007);
      wr(3'd1, 16'h0005);
      irq_in = 4'b0101; tick(1); irq_in = 4'b0000;
      tick(5);
      rd_chk("prio_both", 3'd3, 16'h8000);
      wr(3'd0, 16'h0001);
      rd_chk("prio_after_clr", 3'd3, 16'h8002);

      // Rise coincident with W1C of the same bit
      wr(3'd0, 16'h000F);
      irq_in[1] = 1'b1;
      tick(2);
      wr(3'd0, 16'h0002);
      rd_chk("set_beats_clr", 3'd0, 16'h0002);
      rd_chk("ovf_before", 3'd5, 16'h0000);
      irq_in[1] = 1'b0; tick(3);
      irq_in[1] = 1'b1; tick(5);
`ifdef IRQ_AGG_OVF_EN
      ovf_exp = 16'h0002;
`else
      ovf_exp = 16'h0000;
`endif
      rd_chk("ovf_second_rise", 3'd5, ovf_exp);
      irq_in[1] = 1'b0;
      wr(3'd5, 16'hFFFF);
      rd_chk("ovf_cleared", 3'd5, 16'h0000);
      rd_chk("unused_addr6", 3'd6, 16'h0000);

      // Asynchronous reset with everything pending
      wr(3'd2, 16'h000F);
      wr(3'd1, 16'h000F);
      tick(1);
      irq_in = 4'hF; tick(1); irq_in = 4'h0;
      tick(5);
      rd_chk("all_pending", 3'd0, 16'h000F);
      check("all_irq", {15'h0, irq_out}, 16'h1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_readdata", readdata, 16'h0000);
      check("async_rst_irq_out", {15'h0, irq_out}, 16'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      tick(1);

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'($urandom);
         chipselect = 1'($urandom_range(0, 1));
         write_n    = ($urandom_range(0, 3) != 0);
         address    = 3'($urandom);
         writedata  = 16'($urandom);
         tick(1);
      end
      chipselect = 1'b0; write_n = 1'b1;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
